toggle_event_rx: RTL and testbench
==================================

Name: toggle_event_rx

Overview:
Receiving end of a toggle-encoded event link. The sender flips a single level line once per event, T-flip-flop style. This block synchronizes that line into clk, decodes each level change back into one discrete event, and queues events as a pending count. It presents them downstream on a valid/ready interface and returns a toggle-encoded acknowledge line to the sender, which closes the handshake.

Parameters:
SYNC_STAGES, 2, flops in the input synchronizer chain (legal range 2..4).
CNT_W, 8, width of the event sequence number.
PEND_W, 4, width of the pending counter; maximum pending count is PEND_MAX = 2^PEND_W-1.

Ports:
clk  input  1  single clock; all state on its rising edge.
rst  input  1  asynchronous, active-high reset.
tog_in  input  1  asynchronous toggle line from the sender; one level change = one event.
evt_valid  output  1  at least one event is pending.
evt_ready  input  1  downstream accepts the head event when evt_valid is 1 and evt_ready is 1.
evt_seq  output  CNT_W  sequence number of the head event.
pending  output  PEND_W  number of queued events.
overflow  output  1  sticky; an event was dropped.
clr_ovf  input  1  synchronous clear of overflow.
ack_tog  output  1  toggles once per accepted event; routed back to the sender.
tog_level  output  1  synchronized tog_in level (debug).

Behaviour:
- Reset is asynchronous and active-high. While rst=1, every flop clears immediately without a clock: sync chain, last-level register, pending, evt_seq, overflow, ack_tog and the warm-up counter. All outputs read 0 and the FSM is in WARMUP.
- Synchronizer: tog_in passes through SYNC_STAGES flops. tog_level is the last stage. The sender holds each level for at least 2 clk periods.
- FSM states: WARMUP and RUN.
  - WARMUP: lasts SYNC_STAGES+1 cycles after reset release. Each cycle, last_level <= tog_level. No events are generated. A line that is already high at reset therefore creates no spurious event.
  - RUN: edge = tog_level XOR last_level, and last_level <= tog_level every cycle. RUN is left only by reset.
- Latency: a tog_in change set up before rising edge k raises pending at edge k+SYNC_STAGES. evt_valid is high after that edge (3 edges for the default).
- evt_valid = (pending != 0). It is driven combinationally from the registered pending count. There is no bubble between back-to-back events.
- accept = evt_valid AND evt_ready.
- Pending update:
  - edge only: pending+1.
  - accept only: pending-1.
  - edge and accept in the same cycle: pending unchanged.
- Full (pending = PEND_MAX) with an edge and no accept: the event is dropped, pending stays at PEND_MAX, and overflow <= 1.
- Full with an edge and an accept in the same cycle: pending stays at PEND_MAX and no overflow is flagged.
- Empty: evt_ready is ignored. pending never underflows, and neither evt_seq nor ack_tog changes.
- evt_seq increments by 1 on each accept and wraps modulo 2^CNT_W. Dropped events consume no sequence number.
- ack_tog <= ~ack_tog on each accept, registered, and visible the cycle after the accept.
- overflow: clr_ovf=1 clears it. If clr_ovf and a drop happen in the same cycle, set wins and overflow stays 1.
- Reset mid-operation discards all pending events and returns ack_tog to 0. The sender must be reset in the same domain event.

Decomposition:
- Package toggle_event_pkg holds:
  - the state enum (WARMUP, RUN);
  - default values for SYNC_STAGES, CNT_W and PEND_W;
  - a function computing PEND_MAX from PEND_W.
- One sub-module is natural: sync_chain, with parameter SYNC_STAGES, ports clk, rst, d, q, and the asynchronous clear.

Test Plan:
1. rst released with tog_in=0; tog_in 0->1; evt_ready=1 -> evt_valid high for exactly 1 cycle, 3 edges later; evt_seq=0 during that cycle; ack_tog 0->1 one cycle after; pending back to 0.
2. tog_in held 1 through reset and release; no toggles -> pending=0 and evt_valid=0 for 20 cycles after WARMUP ends.
3. evt_ready=0; 15 toggles spaced 4 cycles -> pending=15, overflow=0. 16th toggle -> pending=15, overflow=1. clr_ovf pulse -> overflow=0. Then evt_ready=1 -> 15 consecutive accepts with evt_seq 0..14 and ack_tog toggling 15 times.
4. pending=15 with an edge landing on the same cycle as an accept -> pending stays 15 and overflow stays 0. Also pending=3 with edge and accept in the same cycle -> pending stays 3.
5. CNT_W=8; 260 events each accepted immediately -> evt_seq runs 0..255 then 0..3; no overflow.
6. pending=5 mid-drain, assert rst between clock edges -> pending, evt_valid, evt_seq, overflow and ack_tog all 0 before the next clk edge; after release no spurious event appears.

Source files
------------

// File: rtl/toggle_event_pkg.sv
// Shared types and defaults for the toggle-encoded event receiver.
package toggle_event_pkg;

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } state_e;

  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned CNT_W_DEF       = 8;
  localparam int unsigned PEND_W_DEF      = 4;

  function automatic int unsigned pend_max(input int unsigned pend_w);
    return (32'd1 << pend_w) - 32'd1;
  endfunction

endpackage

// File: rtl/toggle_event_rx_sync.sv
// Multi-flop synchronizer for a single asynchronous level, cleared by async reset.
module sync_chain #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/toggle_event_rx.sv
// Toggle-event receiver: synchronizes tog_in, decodes level changes into queued
// events, presents them on valid/ready and returns a toggle-encoded acknowledge.
module toggle_event_rx
  import toggle_event_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned PEND_W      = PEND_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tog_in,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CNT_W-1:0]  evt_seq,
  output logic [PEND_W-1:0] pending,
  output logic              overflow,
  input  logic              clr_ovf,
  output logic              ack_tog,
  output logic              tog_level
);

  localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(pend_max(PEND_W));
  localparam int unsigned       WARM_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(SYNC_STAGES);

  state_e            state_q, state_d;
  logic [WARM_W-1:0] warm_q, warm_d;
  logic              last_level_q, last_level_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]  seq_q, seq_d;
  logic              ovf_q, ovf_d;
  logic              ack_q, ack_d;
  logic              tog_edge;
  logic              accept;
  logic              drop;

  sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (tog_in),
    .q  (tog_level)
  );

  assign evt_valid = (pend_q != '0);
  assign accept    = evt_valid & evt_ready;

  always_comb begin
    state_d      = state_q;
    warm_d       = warm_q;
    last_level_d = tog_level;
    tog_edge     = 1'b0;
    case (state_q)
      WARMUP: begin
        // last_level tracks the line here so a level present at reset is absorbed
        if (warm_q == WARM_LAST) state_d = RUN;
        else                     warm_d  = warm_q + WARM_W'(1);
      end
      RUN:     tog_edge = tog_level ^ last_level_q;
      default: state_d  = WARMUP;
    endcase
  end

  always_comb begin
    pend_d = pend_q;
    drop   = 1'b0;
    if (tog_edge && !accept) begin
      if (pend_q == PEND_MAX) drop   = 1'b1;
      else                    pend_d = pend_q + PEND_W'(1);
    end else if (accept && !tog_edge) begin
      pend_d = pend_q - PEND_W'(1);
    end
    seq_d = accept ? seq_q + CNT_W'(1) : seq_q;
    ack_d = accept ? ~ack_q : ack_q;
    // a drop in the same cycle as clr_ovf must still be recorded
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
    else              ovf_d = ovf_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= WARMUP;
      warm_q       <= '0;
      last_level_q <= 1'b0;
      pend_q       <= '0;
      seq_q        <= '0;
      ovf_q        <= 1'b0;
      ack_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      warm_q       <= warm_d;
      last_level_q <= last_level_d;
      pend_q       <= pend_d;
      seq_q        <= seq_d;
      ovf_q        <= ovf_d;
      ack_q        <= ack_d;
    end
  end

  assign evt_seq  = seq_q;
  assign pending  = pend_q;
  assign overflow = ovf_q;
  assign ack_tog  = ack_q;

endmodule

// File: tb/tb_toggle_event_rx.sv
// Scoreboard bench for toggle_event_rx: stimulus pushes expected sequence
// numbers, a negedge monitor pops them on every accept and tracks ack_tog.
module tb_toggle_event_rx;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned CNT_W       = 8;
  localparam int unsigned PEND_W      = 4;

  logic              clk;
  logic              rst;
  logic              tog_in;
  logic              evt_valid;
  logic              evt_ready;
  logic [CNT_W-1:0]  evt_seq;
  logic [PEND_W-1:0] pending;
  logic              overflow;
  logic              clr_ovf;
  logic              ack_tog;
  logic              tog_level;

  int checks   = 0;
  int failures = 0;

  logic [CNT_W-1:0] exp_q[$];
  int unsigned      seq_push = 0;
  logic             ack_exp  = 1'b0;

  toggle_event_rx #(
    .SYNC_STAGES(SYNC_STAGES),
    .CNT_W      (CNT_W),
    .PEND_W     (PEND_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tog_in   (tog_in),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_seq  (evt_seq),
    .pending  (pending),
    .overflow (overflow),
    .clr_ovf  (clr_ovf),
    .ack_tog  (ack_tog),
    .tog_level(tog_level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accept must match the oldest expected sequence number.
  always @(negedge clk) begin
    if (rst) begin
      ack_exp = 1'b0;
    end else begin
      check("ack_tog", 32'(ack_tog), 32'(ack_exp));
      if (evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event: got seq %0d expected none at %0t", evt_seq, $time);
        end else begin
          check("evt_seq", 32'(evt_seq), 32'(exp_q.pop_front()));
        end
        ack_exp = ~ack_exp;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic toggle(input bit keep);
    tog_in = ~tog_in;
    if (keep) begin
      exp_q.push_back(CNT_W'(seq_push));
      seq_push++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    seq_push = 0;
    ticks(3);
    rst = 1'b0;
  endtask

  task automatic quiet_check(input string name, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      tick();
      check(name, 32'(pending), 0);
      check(name, 32'(evt_valid), 0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    tog_in    = 1'b0;
    evt_ready = 1'b0;
    clr_ovf   = 1'b0;
    #1;
    check("reset_valid", 32'(evt_valid), 0);
    check("reset_pending", 32'(pending), 0);
    check("reset_seq", 32'(evt_seq), 0);
    check("reset_ovf", 32'(overflow), 0);
    check("reset_ack", 32'(ack_tog), 0);
    check("reset_level", 32'(tog_level), 0);

    // 1: single event, latency and ack
    do_reset();
    ticks(5);
    evt_ready = 1'b1;
    toggle(1'b1);
    tick();
    check("t1_valid_k", 32'(evt_valid), 0);
    tick();
    check("t1_valid_k1", 32'(evt_valid), 0);
    tick();
    check("t1_valid_k2", 32'(evt_valid), 1);
    check("t1_pending_k2", 32'(pending), 1);
    check("t1_seq_k2", 32'(evt_seq), 0);
    check("t1_ack_k2", 32'(ack_tog), 0);
    tick();
    check("t1_valid_k3", 32'(evt_valid), 0);
    check("t1_pending_k3", 32'(pending), 0);
    check("t1_ack_k3", 32'(ack_tog), 1);
    check("t1_seq_k3", 32'(evt_seq), 1);

    // 2: line already high across reset: no spurious event
    do_reset();
    quiet_check("t2_quiet", 23);

    // 3: fill to full, drop with simultaneous clr_ovf, clear, drain
    evt_ready = 1'b0;
    for (int unsigned i = 0; i < 15; i++) begin
      toggle(1'b1);
      ticks(4);
    end
    ticks(3);
    check("t3_pending_full", 32'(pending), 15);
    check("t3_ovf_before", 32'(overflow), 0);
    toggle(1'b0);
    ticks(2);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("t3_ovf_set_wins", 32'(overflow), 1);
    check("t3_pending_drop", 32'(pending), 15);
    tick();
    check("t3_ovf_sticky", 32'(overflow), 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("t3_ovf_clr", 32'(overflow), 0);
    evt_ready = 1'b1;
    for (int unsigned i = 0; i < 15; i++) begin
      tick();
      check("t3_drain", 32'(pending), 14 - i);
    end
    check("t3_seq_end", 32'(evt_seq), 15);

    // 4: edge coincident with accept at full and at 3
    evt_ready = 1'b0;
    for (int unsigned i = 0; i < 15; i++) begin
      toggle(1'b1);
      ticks(4);
    end
    check("t4_pending_full", 32'(pending), 15);
    toggle(1'b1);
    ticks(2);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    check("t4_full_edge_accept", 32'(pending), 15);
    check("t4_full_no_ovf", 32'(overflow), 0);
    evt_ready = 1'b1;
    ticks(12);
    evt_ready = 1'b0;
    check("t4_pending_3", 32'(pending), 3);
    ticks(4);
    toggle(1'b1);
    ticks(2);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    check("t4_three_edge_accept", 32'(pending), 3);
    evt_ready = 1'b1;
    ticks(3);
    check("t4_drained", 32'(pending), 0);

    // 5: 260 events, immediate accept, sequence wrap
    do_reset();
    ticks(5);
    evt_ready = 1'b1;
    for (int unsigned i = 0; i < 260; i++) begin
      toggle(1'b1);
      ticks(4);
    end
    check("t5_seq_wrap", 32'(evt_seq), 4);
    check("t5_no_ovf", 32'(overflow), 0);
    check("t5_ack_even", 32'(ack_tog), 0);

    // 6: asynchronous reset mid-drain
    evt_ready = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      toggle(1'b1);
      ticks(4);
    end
    evt_ready = 1'b1;
    ticks(3);
    check("t6_pending_5", 32'(pending), 5);
    check("t6_seq_pre", 32'(evt_seq), 7);
    check("t6_ack_pre", 32'(ack_tog), 1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_pending", 32'(pending), 0);
    check("t6_async_valid", 32'(evt_valid), 0);
    check("t6_async_seq", 32'(evt_seq), 0);
    check("t6_async_ovf", 32'(overflow), 0);
    check("t6_async_ack", 32'(ack_tog), 0);
    exp_q.delete();
    seq_push = 0;
    ticks(3);
    rst = 1'b0;
    quiet_check("t6_quiet", 25);
    toggle(1'b1);
    ticks(4);
    check("t6_post_seq", 32'(evt_seq), 1);
    check("t6_queue_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
